tick_bcd_counter: RTL and testbench

TICK_BCD_COUNTER -- requirements
Module: tick_bcd_counter

---
 rtl/tick_pkg.sv | 20 ++
 rtl/edge_sync.sv | 46 ++++
 rtl/tick_bcd_counter.sv | 96 +++++++++
 tb/tb_tick_bcd_counter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tick_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tick_pkg
//  Description : Shared types and constants for the tick-driven BCD counter.
//  Revision    : 1.0  initial release
// ============================================================================
package tick_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } tick_state_e;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;

endpackage
`default_nettype wire

// File: rtl/edge_sync.sv
`default_nettype none
// ============================================================================
//  Module      : edge_sync
//  Description : Synchronizes an asynchronous level and emits a registered
//                one-clock pulse on each rising edge.
//  Revision    : 1.0  initial release
// ============================================================================
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES-1:0] r_fill;
    logic                   r_hist;
    logic                   r_armed;
    logic                   r_rise;

    // r_fill marks when the chain holds real samples; r_armed then waits for
    // a low level so an input already high at reset release never ticks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync  <= '0;
            r_fill  <= '0;
            r_hist  <= 1'b0;
            r_armed <= 1'b0;
            r_rise  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], d};
            r_fill <= {r_fill[SYNC_STAGES-2:0], 1'b1};
            r_hist <= r_sync[SYNC_STAGES-1];
            if (r_fill[SYNC_STAGES-1] && !r_sync[SYNC_STAGES-1]) begin
                r_armed <= 1'b1;
            end
            r_rise <= r_sync[SYNC_STAGES-1] & ~r_hist & r_armed;
        end
    end

    assign rise = r_rise;

endmodule
`default_nettype wire

// File: rtl/tick_bcd_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tick_bcd_counter
//  Description : Multi-decade BCD counter advanced by synchronized rising
//                edges of an external divided clock, with run/pause/clear.
//  Revision    : 1.0  initial release
// ============================================================================
module tick_bcd_counter
    import tick_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_div_in,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  clear,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  tick,
    output logic                  running,
    output logic                  wrap
);

    tick_state_e           r_state;
    tick_state_e           w_state_next;
    logic                  r_running;
    logic                  r_wrap;
    logic [4*DIGITS-1:0]   r_bcd;
    logic [4*DIGITS-1:0]   w_bcd_next;
    logic [DIGITS:0]       w_carry;
    logic                  w_tick;
    logic                  w_inc;

    edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (clk_div_in),
        .rise (w_tick)
    );

    // clear beats stop, stop beats start in every state.
    always_comb begin
        w_state_next = r_state;
        if (clear) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (!stop && start) w_state_next = ST_RUN;
                ST_RUN:   if (stop)           w_state_next = ST_PAUSE;
                ST_PAUSE: if (!stop && start) w_state_next = ST_RUN;
                default:                      w_state_next = ST_IDLE;
            endcase
        end
    end

    assign w_inc      = (r_state == ST_RUN) && w_tick && !clear;
    assign w_carry[0] = w_inc;

    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_decade
            bcd_digit_t w_digit;
            logic       w_at_max;

            assign w_digit          = r_bcd[4*g +: 4];
            assign w_at_max         = (w_digit >= BCD_MAX);
            assign w_carry[g+1]     = w_carry[g] && w_at_max;
            assign w_bcd_next[4*g +: 4] = !w_carry[g] ? w_digit :
                                          (w_at_max ? 4'd0 : w_digit + 4'd1);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_running <= 1'b0;
            r_bcd     <= '0;
            r_wrap    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_running <= (w_state_next == ST_RUN);
            r_bcd     <= clear ? '0 : w_bcd_next;
            r_wrap    <= w_carry[DIGITS];
        end
    end

    assign bcd     = r_bcd;
    assign tick    = w_tick;
    assign running = r_running;
    assign wrap    = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_tick_bcd_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tick_bcd_counter
//  Description : Scoreboard bench for tick_bcd_counter; every input rise that
//                should tick queues the expected post-tick outputs.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_tick_bcd_counter;

    localparam int DIGITS = 4;
    localparam int SS     = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clk_div_in = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] bcd;
    logic        tick;
    logic        running;
    logic        wrap;

    int cyc    = 0;
    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        int          cyc;
        logic [15:0] bcd;
        logic        wrap;
        logic        run;
    } exp_t;

    exp_t sb[$];

    tick_bcd_counter #(
        .DIGITS      (DIGITS),
        .SYNC_STAGES (SS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clk_div_in (clk_div_in),
        .start      (start),
        .stop       (stop),
        .clear      (clear),
        .bcd        (bcd),
        .tick       (tick),
        .running    (running),
        .wrap       (wrap)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int          d;
        r = '0;
        d = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(d % 10);
            d = d / 10;
        end
        return r;
    endfunction

    // Monitor: each tick pops one expectation; outputs are sampled one cycle on.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (tick === 1'b1) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_tick: tick=1 at cycle %0d, expected no tick", cyc);
                end else begin
                    e = sb.pop_front();
                    check("tick_lag", 16'(cyc - e.cyc), 16'(SS + 1));
                    @(negedge clk);
                    check("bcd", bcd, e.bcd);
                    check("wrap", {15'b0, wrap}, {15'b0, e.wrap});
                    check("running", {15'b0, running}, {15'b0, e.run});
                end
            end
        end
    end

    // One clk_div_in pulse; ctl = {start,stop,clear} applied on the tick cycle.
    task automatic pulse(input int hi, input int lo, input logic push,
                         input logic [15:0] eb, input logic ew, input logic er,
                         input logic [2:0] ctl);
        @(negedge clk);
        clk_div_in = 1'b1;
        if (push) sb.push_back('{cyc, eb, ew, er});
        for (int i = 1; i < hi + lo; i++) begin
            @(negedge clk);
            if (i == hi) clk_div_in = 1'b0;
            if (ctl != 3'b000 && i == SS + 1) {start, stop, clear} = ctl;
            if (ctl != 3'b000 && i == SS + 2) {start, stop, clear} = 3'b000;
        end
    endtask

    task automatic ctl(input logic [2:0] c);
        @(negedge clk);
        {start, stop, clear} = c;
        @(negedge clk);
        {start, stop, clear} = 3'b000;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        n_vec++;
        if (sb.size() != 0) begin
            n_miss++;
            $display("FAIL drain: %0d ticks still pending, expected 0", sb.size());
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_bcd", bcd, 16'h0000);
        check("rst_tick", {15'b0, tick}, 16'h0000);
        check("rst_running", {15'b0, running}, 16'h0000);
        check("rst_wrap", {15'b0, wrap}, 16'h0000);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // Start, five slow rises
        ctl(3'b100);
        check("start_running", {15'b0, running}, 16'h0001);
        for (int v = 1; v <= 5; v++) pulse(4, 12, 1'b1, to_bcd(v), 1'b0, 1'b1, 3'b000);
        drain();
        check("five_bcd", bcd, 16'h0005);
        check("five_running", {15'b0, running}, 16'h0001);

        // Stop coincident with tick at 0x0012
        ctl(3'b001);
        check("clear_bcd", bcd, 16'h0000);
        check("clear_running", {15'b0, running}, 16'h0000);
        ctl(3'b100);
        for (int v = 1; v <= 12; v++) pulse(1, 1, 1'b1, to_bcd(v), 1'b0, 1'b1, 3'b000);
        pulse(4, 12, 1'b1, 16'h0013, 1'b0, 1'b0, 3'b010);
        for (int k = 0; k < 3; k++) pulse(4, 12, 1'b1, 16'h0013, 1'b0, 1'b0, 3'b000);
        drain();
        ctl(3'b100);
        check("resume_running", {15'b0, running}, 16'h0001);
        pulse(4, 12, 1'b1, 16'h0014, 1'b0, 1'b1, 3'b000);
        drain();

        // Clear coincident with tick at 0x0042
        ctl(3'b001);
        ctl(3'b100);
        for (int v = 1; v <= 42; v++) pulse(1, 1, 1'b1, to_bcd(v), 1'b0, 1'b1, 3'b000);
        pulse(4, 12, 1'b1, 16'h0000, 1'b0, 1'b0, 3'b001);
        pulse(4, 12, 1'b1, 16'h0000, 1'b0, 1'b0, 3'b000);
        pulse(4, 12, 1'b1, 16'h0000, 1'b0, 1'b0, 3'b000);
        drain();
        ctl(3'b100);
        pulse(4, 12, 1'b1, 16'h0001, 1'b0, 1'b1, 3'b000);
        drain();

        // Control priority
        ctl(3'b111);
        check("all_ctl_bcd", bcd, 16'h0000);
        check("all_ctl_running", {15'b0, running}, 16'h0000);
        ctl(3'b100);
        pulse(4, 12, 1'b1, 16'h0001, 1'b0, 1'b1, 3'b000);
        drain();
        ctl(3'b110);
        check("startstop_running", {15'b0, running}, 16'h0000);
        check("startstop_bcd", bcd, 16'h0001);
        pulse(4, 12, 1'b1, 16'h0001, 1'b0, 1'b0, 3'b000);
        drain();
        ctl(3'b100);
        check("restart_running", {15'b0, running}, 16'h0001);

        // Full wrap from 9999
        ctl(3'b001);
        ctl(3'b100);
        for (int v = 1; v <= 9999; v++) pulse(1, 1, 1'b1, to_bcd(v), 1'b0, 1'b1, 3'b000);
        pulse(4, 12, 1'b1, 16'h0000, 1'b1, 1'b1, 3'b000);
        pulse(4, 12, 1'b1, 16'h0001, 1'b0, 1'b1, 3'b000);
        drain();
        pulse(4, 12, 1'b1, 16'h0002, 1'b0, 1'b1, 3'b000);
        drain();

        // Asynchronous reset mid-count with input held high
        @(negedge clk);
        clk_div_in = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst_bcd", bcd, 16'h0000);
        check("arst_tick", {15'b0, tick}, 16'h0000);
        check("arst_running", {15'b0, running}, 16'h0000);
        check("arst_wrap", {15'b0, wrap}, 16'h0000);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (tick === 1'b1) seen++;
        end
        check("no_tick_after_reset", 16'(seen), 16'h0000);
        clk_div_in = 1'b0;
        repeat (6) @(negedge clk);
        ctl(3'b100);
        pulse(4, 12, 1'b1, 16'h0001, 1'b0, 1'b1, 3'b000);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
